io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Round-robin arbiter sharing the single IO bus between N bus masters (CPU load/store unit, DMA, debug port) and the slave interfaces (RAM, peripherals).
- Owns the bus-grant line BG seen by every slave interface, and multiplexes the owner's addr/ctrl onto the bus.
- Each master drives the shared tristate data bus only while its gnt bit is high.
- Inserts one idle turnaround cycle between owners so two drivers never overlap on the data bus.
- Enforces a maximum tenure unless the owner holds lock.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- MAX_HOLD, 16, max consecutive GRANT cycles before preemption when others wait (>=1).
- HOLD_W, $clog2(MAX_HOLD+1), width of tenure counter.
- ID_W, $clog2(N_MASTERS) (min 1), owner index width.
- Address and control widths come from `IO_BUS_WIDTH_ADDR / `IO_BUS_WIDTH_CTRL in param.v.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_MASTERS  per-master bus request, level, held for whole transfer.
- lock  in  N_MASTERS  per-master lock (atomic sequence); suppresses preemption while owner.
- m_addr  in  N_MASTERS*`IO_BUS_WIDTH_ADDR  flattened master addresses, master i at slice i.
- m_ctrl  in  N_MASTERS*`IO_BUS_WIDTH_CTRL  flattened master ctrl (WE, TYPE_B, TYPE_HB, UNSIGNED).
- gnt  out  N_MASTERS  one-hot registered grant; master i may drive data only when gnt[i].
- BG  out  1  bus grant to slave interfaces, equals |gnt.
- bus_addr  out  `IO_BUS_WIDTH_ADDR  owner's address, 0 when BG=0.
- bus_ctrl  out  `IO_BUS_WIDTH_CTRL  owner's ctrl, 0 when BG=0.
- owner_id  out  ID_W  index of current/last owner.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, BG=0, bus_addr=0, bus_ctrl=0, owner_id=0, rr_ptr=0, hold_cnt=0, busy=0.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0 at a rising edge, winner = first set bit searching from rr_ptr upward with wrap.
  - On that edge: gnt=onehot(winner), owner_id=winner, hold_cnt=1 -> GRANT.
  - Latency is 1 cycle from the req sample to gnt.
- GRANT:
  - bus_addr/bus_ctrl combinationally follow slice owner_id of m_addr/m_ctrl; BG=1.
  - hold_cnt increments and saturates at MAX_HOLD.
  - Release: req[owner]=0 at the edge -> gnt=0, rr_ptr=(owner+1) mod N -> TURN.
  - Preempt: req[owner]=1, lock[owner]=0, hold_cnt==MAX_HOLD and another req bit set -> same as release.
  - lock[owner]=1 blocks preemption indefinitely.
  - No other request pending: the owner keeps the bus regardless of hold_cnt.
- TURN:
  - Exactly one cycle, gnt=0, BG=0.
  - At the next edge, arbitrate as in IDLE using the updated rr_ptr: any req -> GRANT, else -> IDLE.
- Fairness: rr_ptr updates only on release/preempt, so after owner k the search starts at k+1.
  - A master that releases and immediately re-requests waits for all other pending masters.
- Masters that deassert req before being granted are simply skipped; there is no latching of requests.
- lock without req is ignored.
- Simultaneous events:
  - Release and a new request in the same cycle -> TURN, then the new request is granted.
  - All masters requesting -> strict rotation, max wait (N_MASTERS-1)*(MAX_HOLD+1) cycles, excluding locked tenure.
- Reset mid-transfer: gnt/BG drop immediately (async), the bus floats, the master's transfer is lost, and no recovery is attempted.
- gnt is always one-hot or zero; asserting two bits is an error.

Decomposition:
- Add to param.v: `ARB_ST_IDLE/GRANT/TURN 2-bit encodings, `ARB_MAX_MASTERS 8.
- Sub-module rr_pick (combinational): inputs req, rr_ptr; outputs found, winner index. Uses a double-width rotate-and-priority-encode.
- Top module: FSM, counters, addr/ctrl mux.

Test Plan:
- Reset then single request: N=2, req=01 at cycle 3 -> gnt=01, BG=1 from cycle 4; bus_addr=m_addr[0]=0x100; release at cycle 8 -> BG=0 cycle 9, busy=0 cycle 10.
- Turnaround: req=11 held, master0 wins. After master0 drops req at cycle 10 -> exactly one cycle of gnt=00, then gnt=10; never 11.
- Round robin: N=4, all req held, MAX_HOLD=4 -> grants rotate 0,1,2,3,0; each tenure 4 cycles separated by 1 TURN cycle.
- Lock: master1 owner with lock=1 and master0 requesting for 40 cycles, MAX_HOLD=16 -> no preemption. Lock falls -> preempt at the next edge (hold_cnt saturated), master0 granted after TURN.
- Sole requester beyond MAX_HOLD: req=01 for 50 cycles -> gnt stays 01 throughout.
- Async reset during GRANT: rst_n low mid-cycle -> gnt, BG, bus_addr, bus_ctrl go 0 without a clock edge. After release, re-arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared widths, state encodings and types for the IO bus arbiter.
// Bus widths fall back to 32-bit address / 4-bit ctrl unless defined earlier.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef ARB_ST_IDLE
`define ARB_ST_IDLE 2'd0
`endif
`ifndef ARB_ST_GRANT
`define ARB_ST_GRANT 2'd1
`endif
`ifndef ARB_ST_TURN
`define ARB_ST_TURN 2'd2
`endif
`ifndef ARB_MAX_MASTERS
`define ARB_MAX_MASTERS 8
`endif

package io_bus_arbiter_pkg;

    localparam int ADDR_W      = `IO_BUS_WIDTH_ADDR;
    localparam int CTRL_W      = `IO_BUS_WIDTH_CTRL;
    localparam int MAX_MASTERS = `ARB_MAX_MASTERS;

    // Bit positions inside a master's ctrl slice.
    localparam int CTRL_WE       = 0;
    localparam int CTRL_TYPE_B   = 1;
    localparam int CTRL_TYPE_HB  = 2;
    localparam int CTRL_UNSIGNED = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = `ARB_ST_IDLE,
        ST_GRANT = `ARB_ST_GRANT,
        ST_TURN  = `ARB_ST_TURN
    } arb_state_e;

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr,
// wrapping around, found by rotating a doubled request vector.
module io_bus_arbiter_rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] winner
);

    localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N);

    logic [2*N-1:0]  doubled;
    logic [N-1:0]    rotated;
    logic [ID_W-1:0] offset;
    logic [ID_W:0]   sum;

    // Descending loop so the lowest rotated bit (closest to ptr) wins.
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N-1:0];
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end
        winner = sum[ID_W-1:0];
        found  = |req;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin IO bus arbiter with one-cycle turnaround between owners,
// tenure limit with preemption, and lock to protect atomic sequences.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 16,
    parameter int HOLD_W    = $clog2(MAX_HOLD + 1),
    parameter int ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS-1:0]        req,
    input  logic [N_MASTERS-1:0]        lock,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*CTRL_W-1:0] m_ctrl,
    output logic [N_MASTERS-1:0]        gnt,
    output logic                        BG,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [CTRL_W-1:0]           bus_ctrl,
    output logic [ID_W-1:0]             owner_id,
    output logic                        busy
);

    localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]      LAST_ID  = ID_W'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = N_MASTERS'(1);

    arb_state_e            state, state_next;
    logic [N_MASTERS-1:0]  gnt_next;
    logic [ID_W-1:0]       owner_next;
    logic [ID_W-1:0]       rr_ptr, rr_ptr_next;
    logic [HOLD_W-1:0]     hold_cnt, hold_next;
    logic                  found;
    logic [ID_W-1:0]       winner;
    logic [N_MASTERS-1:0]  owner_mask;
    logic                  others_pending;
    logic                  release_bus;

    io_bus_arbiter_rr_pick #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            owner_id <= owner_next;
            rr_ptr   <= rr_ptr_next;
            hold_cnt <= hold_next;
        end
    end

    // Owner gives up the bus when it drops req, or when its tenure is spent,
    // it is not locked and someone else is waiting.
    always_comb begin
        owner_mask     = ONE_HOT0 << owner_id;
        others_pending = |(req & ~owner_mask);
        release_bus    = !req[owner_id] ||
                         (!lock[owner_id] && (hold_cnt == HOLD_MAX) && others_pending);

        state_next  = state;
        gnt_next    = gnt;
        owner_next  = owner_id;
        rr_ptr_next = rr_ptr;
        hold_next   = hold_cnt;

        case (state)
            ST_IDLE, ST_TURN: begin
                if (found) begin
                    gnt_next   = ONE_HOT0 << winner;
                    owner_next = winner;
                    hold_next  = HOLD_W'(1);
                    state_next = ST_GRANT;
                end else begin
                    gnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_bus) begin
                    gnt_next    = '0;
                    rr_ptr_next = (owner_id == LAST_ID) ? '0 : owner_id + ID_W'(1);
                    hold_next   = '0;
                    state_next  = ST_TURN;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address/ctrl are forced to zero whenever nobody holds the bus.
    always_comb begin
        bus_addr = '0;
        bus_ctrl = '0;
        if (BG) begin
            bus_addr = m_addr[owner_id*ADDR_W +: ADDR_W];
            bus_ctrl = m_ctrl[owner_id*CTRL_W +: CTRL_W];
        end
    end

    assign BG   = |gnt;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench: a 2-master arbiter (MAX_HOLD=16) for grant, turnaround,
// lock and reset cases, and a 4-master one (MAX_HOLD=4) for rotation.
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;

    logic clk;
    logic rst_n;

    logic [1:0]          req2, lock2, gnt2;
    logic [2*ADDR_W-1:0] m_addr2;
    logic [2*CTRL_W-1:0] m_ctrl2;
    logic                bg2, busy2;
    logic [ADDR_W-1:0]   bus_addr2;
    logic [CTRL_W-1:0]   bus_ctrl2;
    logic [0:0]          owner2;

    logic [3:0]          req4, lock4, gnt4;
    logic [4*ADDR_W-1:0] m_addr4;
    logic [4*CTRL_W-1:0] m_ctrl4;
    logic                bg4, busy4;
    logic [ADDR_W-1:0]   bus_addr4;
    logic [CTRL_W-1:0]   bus_ctrl4;
    logic [1:0]          owner4;

    int checks   = 0;
    int failures = 0;

    io_bus_arbiter #(.N_MASTERS(2), .MAX_HOLD(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .lock(lock2),
        .m_addr(m_addr2), .m_ctrl(m_ctrl2), .gnt(gnt2), .BG(bg2),
        .bus_addr(bus_addr2), .bus_ctrl(bus_ctrl2), .owner_id(owner2), .busy(busy2)
    );

    io_bus_arbiter #(.N_MASTERS(4), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .lock(lock4),
        .m_addr(m_addr4), .m_ctrl(m_ctrl4), .gnt(gnt4), .BG(bg4),
        .bus_addr(bus_addr4), .bus_ctrl(bus_ctrl4), .owner_id(owner4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] r2, input logic [1:0] l2);
        req2  = r2;
        lock2 = l2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] exp_m;
        m_addr2 = {32'h0000_0200, 32'h0000_0100};
        m_ctrl2 = {4'h3, 4'h9};
        m_addr4 = {32'h0000_1030, 32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
        m_ctrl4 = {4'h4, 4'h3, 4'h2, 4'h1};
        req4    = '0;
        lock4   = '0;
        apply_stimulus(2'b00, 2'b00);
        rst_n   = 1'b0;

        tick();
        tick();
        check_output("reset_gnt", 32'(gnt2), 32'h0);
        check_output("reset_bg", 32'(bg2), 32'h0);
        check_output("reset_addr", bus_addr2, 32'h0);
        check_output("reset_owner", 32'(owner2), 32'h0);
        check_output("reset_busy", 32'(busy2), 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single request and release");
        apply_stimulus(2'b01, 2'b00);
        #2;
        check_output("latency_no_gnt_yet", 32'(gnt2), 32'h0);
        tick();
        check_output("single_gnt", 32'(gnt2), 32'h1);
        check_output("single_bg", 32'(bg2), 32'h1);
        check_output("single_addr", bus_addr2, 32'h100);
        check_output("single_ctrl", 32'(bus_ctrl2), 32'h9);
        check_output("single_busy", 32'(busy2), 32'h1);
        tick();
        tick();
        tick();
        apply_stimulus(2'b00, 2'b00);
        tick();
        check_output("release_bg", 32'(bg2), 32'h0);
        check_output("release_addr", bus_addr2, 32'h0);
        check_output("turn_busy", 32'(busy2), 32'h1);
        tick();
        check_output("idle_busy", 32'(busy2), 32'h0);

        $display("[TB] turnaround with both requesting, pointer at master1");
        apply_stimulus(2'b11, 2'b00);
        tick();
        check_output("turn_first_gnt", 32'(gnt2), 32'h2);
        check_output("turn_first_addr", bus_addr2, 32'h200);
        check_output("turn_first_ctrl", 32'(bus_ctrl2), 32'h3);
        tick();
        tick();
        apply_stimulus(2'b01, 2'b00);
        tick();
        check_output("turn_gap_gnt", 32'(gnt2), 32'h0);
        check_output("turn_gap_bg", 32'(bg2), 32'h0);
        tick();
        check_output("turn_second_gnt", 32'(gnt2), 32'h1);
        check_output("turn_second_owner", 32'(owner2), 32'h0);

        $display("[TB] sole requester beyond MAX_HOLD");
        for (int c = 0; c < 50; c++) begin
            tick();
            check_output("sole_hold_gnt", 32'(gnt2), 32'h1);
        end

        $display("[TB] locked owner is not preempted");
        apply_stimulus(2'b00, 2'b00);
        tick();
        apply_stimulus(2'b10, 2'b10);
        tick();
        check_output("lock_owner_gnt", 32'(gnt2), 32'h2);
        apply_stimulus(2'b11, 2'b10);
        for (int c = 0; c < 40; c++) begin
            tick();
            check_output("lock_hold_gnt", 32'(gnt2), 32'h2);
        end
        apply_stimulus(2'b11, 2'b00);
        tick();
        check_output("unlock_preempt_gnt", 32'(gnt2), 32'h0);
        check_output("unlock_preempt_busy", 32'(busy2), 32'h1);
        tick();
        check_output("unlock_next_gnt", 32'(gnt2), 32'h1);
        check_output("unlock_next_owner", 32'(owner2), 32'h0);

        $display("[TB] async reset during grant");
        apply_stimulus(2'b10, 2'b00);
        tick();
        tick();
        check_output("pre_reset_gnt", 32'(gnt2), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_gnt", 32'(gnt2), 32'h0);
        check_output("async_bg", 32'(bg2), 32'h0);
        check_output("async_addr", bus_addr2, 32'h0);
        check_output("async_ctrl", 32'(bus_ctrl2), 32'h0);
        tick();
        apply_stimulus(2'b11, 2'b00);
        rst_n = 1'b1;
        tick();
        check_output("post_reset_gnt", 32'(gnt2), 32'h1);
        apply_stimulus(2'b00, 2'b00);

        $display("[TB] four-master rotation");
        req4 = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_m = 2'(k % 4);
            check_output("rot_owner", 32'(owner4), 32'(exp_m));
            check_output("rot_addr", bus_addr4, 32'h1000 + 32'(exp_m) * 32'h10);
            for (int c = 0; c < 4; c++) begin
                check_output("rot_gnt", 32'(gnt4), 32'h1 << exp_m);
                tick();
            end
            check_output("rot_turn_gnt", 32'(gnt4), 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
